univ_shift_reg: RTL and testbench

//   Parametrised universal shift register: successor to the single-bit D flip-flop.

---
 rtl/univ_shift_reg.sv | 167 ++++++++++++++++
 tb/tb_univ_shift_reg.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
//   Parametrised universal shift register. It holds, shifts right, shifts
//   left or parallel-loads a WIDTH-bit word, and it has a clock enable and
//   serial in/out at both ends. A saturating shift counter raises a sticky
//   done flag once a full word has been shifted out.
//
// Parameters
//   WIDTH     register width in bits (WIDTH >= 2)
//   RESET_VAL value of q after reset
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high reset (highest priority)
//   en      in   clock enable; 0 freezes q, cnt and done
//   mode    in   00 hold, 01 shift right, 10 shift left, 11 load
//   d       in   parallel load data
//   sin_r   in   serial input entering q[WIDTH-1] on a right shift
//   sin_l   in   serial input entering q[0] on a left shift
//   rot     in   rotate select (only acts in ROTATE_EN builds)
//   q       out  register contents (registered)
//   sout_r  out  q[0]
//   sout_l  out  q[WIDTH-1]
//   cnt     out  shifts since the last load/reset, saturating at WIDTH
//   done    out  sticky flag, set on the edge where cnt reaches WIDTH
//
// Configuration macro
//   ROTATE_EN  when defined, rot=1 during a shift feeds the outgoing bit back
//              in place of the serial input. When undefined, rot is ignored.
// ---------------------------------------------------------------------------
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           d,
  input  logic                       sin_r,
  input  logic                       sin_l,
  input  logic                       rot,
  output logic [WIDTH-1:0]           q,
  output logic                       sout_r,
  output logic                       sout_l,
  output logic [$clog2(WIDTH+1)-1:0] cnt,
  output logic                       done
);

  localparam int             CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  // Shift right by one, with fill_bit entering at the MSB.
  function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] v,
                                                   input logic             fill_bit);
    return {fill_bit, v[WIDTH-1:1]};
  endfunction

  // Shift left by one, with fill_bit entering at the LSB.
  function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] v,
                                                  input logic             fill_bit);
    return {v[WIDTH-2:0], fill_bit};
  endfunction

  // Saturating increment of the shift counter.
  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? CNT_MAX : (c + {{(CW-1){1'b0}}, 1'b1});
  endfunction

  logic [WIDTH-1:0] q_r;
  logic [CW-1:0]    cnt_r;
  logic             done_r;

  logic [WIDTH-1:0] q_next_s;
  logic [CW-1:0]    cnt_next_s;
  logic             done_next_s;
  logic             fill_r_s;
  logic             fill_l_s;

`ifdef ROTATE_EN
  // Select the serial fill bits: with rotate, the bit shifted out wraps around.
  always_comb begin
    fill_r_s = sin_r;
    fill_l_s = sin_l;
    if (rot) begin
      fill_r_s = q_r[0];
      fill_l_s = q_r[WIDTH-1];
    end else begin
      fill_r_s = sin_r;
      fill_l_s = sin_l;
    end
  end
`else
  logic unused_rot_s;
  assign unused_rot_s = rot;

  // Select the serial fill bits: straight from the serial inputs.
  always_comb begin
    fill_r_s = sin_r;
    fill_l_s = sin_l;
  end
`endif

  // Decode the mode into the next register state (the enable is applied in the flop).
  always_comb begin
    q_next_s    = q_r;
    cnt_next_s  = cnt_r;
    done_next_s = done_r;
    case (mode)
      MODE_HOLD: begin
        q_next_s    = q_r;
        cnt_next_s  = cnt_r;
        done_next_s = done_r;
      end
      MODE_RIGHT: begin
        q_next_s    = shift_right(q_r, fill_r_s);
        cnt_next_s  = cnt_inc(cnt_r);
        // done is sticky; it rises on the edge where cnt reaches WIDTH
        done_next_s = done_r | (cnt_inc(cnt_r) == CNT_MAX);
      end
      MODE_LEFT: begin
        q_next_s    = shift_left(q_r, fill_l_s);
        cnt_next_s  = cnt_inc(cnt_r);
        done_next_s = done_r | (cnt_inc(cnt_r) == CNT_MAX);
      end
      MODE_LOAD: begin
        q_next_s    = d;
        cnt_next_s  = {CW{1'b0}};
        done_next_s = 1'b0;
      end
      default: begin
        q_next_s    = q_r;
        cnt_next_s  = cnt_r;
        done_next_s = done_r;
      end
    endcase
  end

  // State registers: reset wins over enable, and enable wins over mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r    <= RESET_VAL;
      cnt_r  <= {CW{1'b0}};
      done_r <= 1'b0;
    end else if (en) begin
      q_r    <= q_next_s;
      cnt_r  <= cnt_next_s;
      done_r <= done_next_s;
    end else begin
      q_r    <= q_r;
      cnt_r  <= cnt_r;
      done_r <= done_r;
    end
  end

  assign q      = q_r;
  assign cnt    = cnt_r;
  assign done   = done_r;
  assign sout_r = q_r[0];
  assign sout_l = q_r[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_univ_shift_reg
//   Self-checking bench for univ_shift_reg with WIDTH=8 and RESET_VAL=0.
//   A behavioural model (integer arithmetic on the word and the count) runs
//   beside the DUT. Directed scenarios are followed by random stimulus.
//   ROTATE_EN is honoured in the same way as in the design.
// ---------------------------------------------------------------------------
module tb_univ_shift_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] d;
  logic         sin_r;
  logic         sin_l;
  logic         rot;
  logic [W-1:0] q;
  logic         sout_r;
  logic         sout_l;
  logic [3:0]   cnt;
  logic         done;

  int checks = 0;
  int errors = 0;

  // reference model state
  int unsigned m_q;
  int unsigned m_cnt;
  bit          m_done;
  bit          rotate_build;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
    .sin_r(sin_r), .sin_l(sin_l), .rot(rot),
    .q(q), .sout_r(sout_r), .sout_l(sout_l), .cnt(cnt), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"},      {24'h0, q},         m_q);
    chk({tag, ".cnt"},    {28'h0, cnt},       m_cnt);
    chk({tag, ".done"},   {31'h0, done},      {31'h0, m_done});
    chk({tag, ".sout_r"}, {31'h0, sout_r},    m_q & 32'd1);
    chk({tag, ".sout_l"}, {31'h0, sout_l},    (m_q >> 7) & 32'd1);
  endtask

  // Model update for one rising edge, written from the behavioural rules.
  task automatic model_edge();
    int unsigned fill;
    if (reset) begin
      m_q = 0; m_cnt = 0; m_done = 0;
    end else if (en) begin
      if (mode == 2'b11) begin
        m_q = d; m_cnt = 0; m_done = 0;
      end else if (mode == 2'b01 || mode == 2'b10) begin
        if (mode == 2'b01) begin
          fill = (rotate_build && rot) ? (m_q % 2) : sin_r;
          m_q  = (m_q / 2) + fill * 128;
        end else begin
          fill = (rotate_build && rot) ? (m_q / 128) : sin_l;
          m_q  = ((m_q * 2) % 256) + fill;
        end
        if (m_cnt < W) m_cnt = m_cnt + 1;
        if (m_cnt == W) m_done = 1;
      end
    end
  endtask

  // Drive one cycle of inputs at negedge, advance the model at posedge, check 1 time unit later.
  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [W-1:0] dv, input logic sr, input logic sl,
                      input logic ro, input string tag);
    @(negedge clk);
    reset = r; en = e; mode = m; d = dv; sin_r = sr; sin_l = sl; rot = ro;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
`ifdef ROTATE_EN
    rotate_build = 1'b1;
`else
    rotate_build = 1'b0;
`endif
    reset = 1'b1; en = 1'b0; mode = 2'b11; d = 8'hFF;
    sin_r = 1'b0; sin_l = 1'b0; rot = 1'b0;
    m_q = 0; m_cnt = 0; m_done = 0;

    // 1: reset wins over load
    step(1'b1, 1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0, "reset");
    chk("reset.q_const", {24'h0, q}, 32'h00);

    // 2: load A5 then 9 right shifts with sin_r=0
    step(1'b0, 1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0, "load_a5");
    for (int i = 0; i < 9; i++)
      step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, "shr_a5");
    chk("shr_a5.q_const",    {24'h0, q},    32'h00);
    chk("shr_a5.cnt_const",  {28'h0, cnt},  32'd8);
    chk("shr_a5.done_const", {31'h0, done}, 32'd1);

    // 3: load 01, shift left with a frozen middle edge
    step(1'b0, 1'b1, 2'b11, 8'h01, 1'b0, 1'b0, 1'b0, "load_01");
    step(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0, "shl_1");
    step(1'b0, 1'b0, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0, "shl_frozen");
    step(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0, "shl_3");
    chk("shl.q_const", {24'h0, q}, 32'h07);

    // 4: reset mid-word, then reload
    step(1'b0, 1'b1, 2'b11, 8'h3C, 1'b0, 1'b0, 1'b0, "load_3c");
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, "shr_3c");
    step(1'b1, 1'b0, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, "reset_mid");
    step(1'b0, 1'b1, 2'b11, 8'h3C, 1'b0, 1'b0, 1'b0, "reload_3c");

    // 5: rotate (or plain shift in the default build)
    step(1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0, "load_81");
    step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b1, "rot_1");
    chk("rot_1.q_const", {24'h0, q}, rotate_build ? 32'hC0 : 32'h40);
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b1, "rot_n");
    chk("rot_8.done_const", {31'h0, done}, 32'd1);

    // hold mode keeps everything
    step(1'b0, 1'b1, 2'b00, 8'h5A, 1'b1, 1'b1, 1'b0, "hold");

    // random stimulus: reset rare, load occasional
    for (int i = 0; i < 400; i++) begin
      logic         r_rst;
      logic         r_en;
      logic [1:0]   r_mode;
      r_rst  = ($urandom_range(0, 39) == 0);
      r_en   = ($urandom_range(0, 4) != 0);
      r_mode = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      step(r_rst, r_en, r_mode, 8'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
